// File: rtl/write_reg_osd.sv
// write_reg_osd: OSD register-write decoder; staged geometry/colour commit at frame start.
// Optional WR_BYTE_STROBE_EN adds mem_wr_be byte-lane strobes.
module write_reg_osd #(
    parameter int          ADDR_DECODER_WIDTH = 8,
    parameter logic [15:0] H_RES_DEFAULT      = 16'd1920,
    parameter logic [15:0] V_RES_DEFAULT      = 16'd1080,
    parameter logic [23:0] RGB_DEFAULT        = 24'hFFFFFF
) (
    input  logic        sys_clk,
    input  logic        resetn,
    input  logic        mem_wr_valid,
    input  logic [31:0] mem_wr_addr,
    input  logic [31:0] mem_wr_data,
`ifdef WR_BYTE_STROBE_EN
    input  logic [3:0]  mem_wr_be,
`endif
    output logic        mem_wr_ack,
    input  logic        frame_start,
    output logic [31:0] ctrl_reg,
    output logic [31:0] coordinate,
    output logic [23:0] rgb_color,
    output logic [15:0] osd_num,
    output logic [15:0] h_res,
    output logic [15:0] v_res,
    output logic        update_pending
);
    localparam int AW = ADDR_DECODER_WIDTH;

    logic [AW-1:0] off;
    logic [3:0]    be;
    logic [31:0]   m;
    logic          wr_ctrl, wr_coord, wr_rgb, wr_osd, wr_h, wr_v, stage_wr, frame_rise, commit;
    logic          ack_q, fs_q, pend_q, pend_d;
    logic [31:0]   ctrl_q, ctrl_d, ctrl_base, coord_q, st_coord_q, st_coord_d;
    logic [23:0]   rgb_q, st_rgb_q, st_rgb_d;
    logic [15:0]   osd_q, h_q, v_q, st_osd_q, st_osd_d, st_h_q, st_h_d, st_v_q, st_v_d;
    logic          unused_addr;

`ifdef WR_BYTE_STROBE_EN
    assign be = mem_wr_be;
`else
    assign be = 4'hF;
`endif

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] msk);
        return (old & ~msk) | (wd & msk);
    endfunction

    assign unused_addr = ^mem_wr_addr[31:AW];
    assign off         = mem_wr_addr[AW-1:0];
    assign m           = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign wr_ctrl     = mem_wr_valid && off == AW'('h04);
    assign wr_coord    = mem_wr_valid && off == AW'('h08);
    assign wr_rgb      = mem_wr_valid && off == AW'('h0C);
    assign wr_osd      = mem_wr_valid && off == AW'('h10);
    assign wr_h        = mem_wr_valid && off == AW'('h14);
    assign wr_v        = mem_wr_valid && off == AW'('h18);
    assign stage_wr    = (wr_coord | wr_rgb | wr_osd | wr_h | wr_v) & |be;
    assign frame_rise  = frame_start & ~fs_q;
    assign commit      = pend_q & (frame_rise | ctrl_q[1] | ctrl_q[2]);

    // force_commit is cleared before any new write lands, so a strobe-masked write can't keep it set
    always_comb begin
        ctrl_base  = {ctrl_q[31:3], 1'b0, ctrl_q[1:0]};
        ctrl_d     = wr_ctrl ? merge(ctrl_base, mem_wr_data, m) : ctrl_base;
        st_coord_d = wr_coord ? merge(st_coord_q, mem_wr_data, m) : st_coord_q;
        st_rgb_d   = wr_rgb ? 24'(merge({8'h0, st_rgb_q}, mem_wr_data, m)) : st_rgb_q;
        st_osd_d   = wr_osd ? 16'(merge({16'h0, st_osd_q}, mem_wr_data, m)) : st_osd_q;
        st_h_d     = wr_h ? 16'(merge({16'h0, st_h_q}, mem_wr_data, m)) : st_h_q;
        st_v_d     = wr_v ? 16'(merge({16'h0, st_v_q}, mem_wr_data, m)) : st_v_q;
        pend_d     = stage_wr | (pend_q & ~commit);
    end

    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            ack_q      <= 1'b0;
            fs_q       <= 1'b0;
            pend_q     <= 1'b0;
            ctrl_q     <= '0;
            st_coord_q <= '0;
            st_rgb_q   <= RGB_DEFAULT;
            st_osd_q   <= '0;
            st_h_q     <= H_RES_DEFAULT;
            st_v_q     <= V_RES_DEFAULT;
            coord_q    <= '0;
            rgb_q      <= RGB_DEFAULT;
            osd_q      <= '0;
            h_q        <= H_RES_DEFAULT;
            v_q        <= V_RES_DEFAULT;
        end else begin
            ack_q      <= mem_wr_valid;
            fs_q       <= frame_start;
            pend_q     <= pend_d;
            ctrl_q     <= ctrl_d;
            st_coord_q <= st_coord_d;
            st_rgb_q   <= st_rgb_d;
            st_osd_q   <= st_osd_d;
            st_h_q     <= st_h_d;
            st_v_q     <= st_v_d;
            if (commit) begin
                coord_q <= st_coord_q;
                rgb_q   <= st_rgb_q;
                osd_q   <= st_osd_q;
                h_q     <= st_h_q;
                v_q     <= st_v_q;
            end
        end
    end

    assign mem_wr_ack     = ack_q;
    assign ctrl_reg       = ctrl_q;
    assign coordinate     = coord_q;
    assign rgb_color      = rgb_q;
    assign osd_num        = osd_q;
    assign h_res          = h_q;
    assign v_res          = v_q;
    assign update_pending = pend_q;
endmodule

// File: tb/tb_write_reg_osd.sv
// tb_write_reg_osd: scoreboard bench; each write pushes the register snapshot expected at its ack.
module tb_write_reg_osd;
    typedef struct packed {
        logic [31:0] ctrl;
        logic [31:0] coord;
        logic [23:0] rgb;
        logic [15:0] osd;
        logic [15:0] h;
        logic [15:0] v;
        logic        pend;
    } snap_t;

    logic        sys_clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_wr_valid = 1'b0;
    logic [31:0] mem_wr_addr = '0;
    logic [31:0] mem_wr_data = '0;
    logic [3:0]  be = 4'hF;
    logic        frame_start = 1'b0;
    logic        mem_wr_ack, update_pending;
    logic [31:0] ctrl_reg, coordinate;
    logic [23:0] rgb_color;
    logic [15:0] osd_num, h_res, v_res;

    snap_t q[$];
    int    checks = 0;
    int    failures = 0;

    write_reg_osd dut (
        .sys_clk(sys_clk), .resetn(resetn), .mem_wr_valid(mem_wr_valid),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
`ifdef WR_BYTE_STROBE_EN
        .mem_wr_be(be),
`endif
        .mem_wr_ack(mem_wr_ack), .frame_start(frame_start), .ctrl_reg(ctrl_reg),
        .coordinate(coordinate), .rgb_color(rgb_color), .osd_num(osd_num),
        .h_res(h_res), .v_res(v_res), .update_pending(update_pending)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_snap(input string tag, input snap_t e);
        chk({tag, " ctrl"}, ctrl_reg, e.ctrl);
        chk({tag, " coord"}, coordinate, e.coord);
        chk({tag, " rgb"}, {8'h0, rgb_color}, {8'h0, e.rgb});
        chk({tag, " osd"}, {16'h0, osd_num}, {16'h0, e.osd});
        chk({tag, " h_res"}, {16'h0, h_res}, {16'h0, e.h});
        chk({tag, " v_res"}, {16'h0, v_res}, {16'h0, e.v});
        chk({tag, " pending"}, {31'h0, update_pending}, {31'h0, e.pend});
    endtask

    // One write per cycle; e is the state expected right after the write edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic fs, input snap_t e);
        mem_wr_valid = 1'b1;
        mem_wr_addr  = a;
        mem_wr_data  = d;
        frame_start  = fs;
        q.push_back(e);
        @(posedge sys_clk);
        #1;
        mem_wr_valid = 1'b0;
        be = 4'hF;
    endtask

    initial begin : monitor
        forever begin
            @(negedge sys_clk);
            if (resetn && mem_wr_ack) begin
                if (q.size() == 0) begin
                    chk("unexpected ack", 32'd1, 32'd0);
                end else begin
                    chk_snap("ack", q.pop_front());
                end
            end
        end
    end

    localparam snap_t RST = '{32'h0, 32'h0, 24'hFFFFFF, 16'h0, 16'd1920, 16'd1080, 1'b0};

    initial begin : stim
        snap_t s;
        repeat (3) @(posedge sys_clk);
        #1 resetn = 1'b1;
        @(negedge sys_clk);
        chk_snap("reset", RST);
        chk("reset ack", {31'h0, mem_wr_ack}, 32'h0);
        @(posedge sys_clk);
        #1;
        s = RST;
        s.pend = 1;                          wr(32'h08, 32'h0040_0020, 0, s);
        s.coord = 32'h0040_0020; s.pend = 0; wr(32'h00, 32'hDEAD, 1, s);
                                             wr(32'h00, 32'h0, 1, s);
        s.pend = 1;                          wr(32'h10, 32'h0001_2345, 1, s);
                                             wr(32'h00, 32'h0, 1, s);
                                             wr(32'h00, 32'h0, 0, s);
        s.osd = 16'h2345;                    wr(32'h14, 32'd1280, 1, s);
                                             wr(32'h00, 32'h0, 0, s);
        s.h = 16'd1280; s.pend = 0;          wr(32'h00, 32'h0, 1, s);
                                             wr(32'h40, 32'hFFFF_FFFF, 1, s);
        s.ctrl = 32'h2;                      wr(32'h04, 32'h2, 0, s);
        s.pend = 1;                          wr(32'h0C, 32'h1200_FF00, 0, s);
        s.rgb = 24'h00FF00; s.pend = 0;      wr(32'h00, 32'h0, 0, s);
        s.ctrl = 32'h0;                      wr(32'h04, 32'h0, 0, s);
        s.pend = 1;                          wr(32'h108, 32'h0005_0006, 0, s);
        s.ctrl = 32'hF000_0004;              wr(32'h04, 32'hF000_0004, 0, s);
        s.ctrl = 32'hF000_0000; s.coord = 32'h0005_0006; s.pend = 0;
                                             wr(32'h00, 32'h0, 0, s);
        s.pend = 1;                          wr(32'h18, 32'h0000_02D0, 0, s);
        s.v = 16'h02D0; s.pend = 0;          wr(32'h00, 32'h0, 1, s);
`ifdef WR_BYTE_STROBE_EN
        be = 4'b0001; s.pend = 1;            wr(32'h0C, 32'h0011_2233, 0, s);
        s.rgb = 24'h00FF33; s.pend = 0;      wr(32'h00, 32'h0, 1, s);
        be = 4'b0000;                        wr(32'h10, 32'hFFFF_FFFF, 0, s);
`endif
        frame_start = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("scoreboard drained", q.size(), 32'd0);
        mem_wr_valid = 1'b1;
        mem_wr_addr  = 32'h14;
        mem_wr_data  = 32'd640;
        #2 resetn = 1'b0;
        @(negedge sys_clk);
        chk_snap("mid reset", RST);
        chk("mid reset ack", {31'h0, mem_wr_ack}, 32'h0);
        mem_wr_valid = 1'b0;
        @(posedge sys_clk);
        #1 resetn = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk("post reset ack", {31'h0, mem_wr_ack}, 32'h0);
        chk("post reset h_res", {16'h0, h_res}, 32'd1920);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
